ibex_rf_store: RTL and testbench

//  Memory-side responder for register-file spill/fill traffic on the Ibex data interface.

---
 rtl/ibex_rf_store.sv | 141 ++++++++++++++
 tb/tb_ibex_rf_store.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_store.sv
// Register-file spill/fill store: NumRegFiles windows of 32 words with a fixed-latency response
// pipe and a bulk zeroize sequence. Optional macro: IBEX_RF_STORE_ZERO_X0_EN (x0 slots read as 0).
module ibex_rf_store #(
  parameter logic [31:0] BaseAddr    = 32'h0001_0000,
  parameter int unsigned NumRegFiles = 8,
  parameter int unsigned Latency     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        clear_i,
  output logic        busy_o
);

  localparam int unsigned NumWords = NumRegFiles * 32;
  localparam int unsigned AddrW    = $clog2(NumRegFiles * 128);
  localparam int unsigned IdxW     = $clog2(NumWords);

  if (NumRegFiles < 1 || NumRegFiles > 32 || (NumRegFiles & (NumRegFiles - 1)) != 0) begin : gen_nrf_chk
    $error("NumRegFiles must be a power of 2 in 1..32");
  end
  if (Latency < 1 || Latency > 4) begin : gen_lat_chk
    $error("Latency must be in 1..4");
  end

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem_q [NumWords];

  logic            hit;
  logic [IdxW-1:0] idx;
  logic            gnt;
  logic            wr_en;
  logic            rd_en;
  logic            slot_ro;
  logic            unused_addr;

  assign hit         = (data_addr_i[31:AddrW] == BaseAddr[31:AddrW]);
  assign idx         = data_addr_i[AddrW-1:2];
  assign unused_addr = ^data_addr_i[1:0];

`ifdef IBEX_RF_STORE_ZERO_X0_EN
  // x0 is architecturally zero, so its slot is never stored.
  assign slot_ro = (data_addr_i[6:2] == 5'd0);
`else
  assign slot_ro = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A clear pulse takes priority; a coincident request simply waits.
        if (clear_i) begin
          state_d = StClear;
        end else begin
          gnt = data_req_i;
        end
      end
      StClear: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + IdxW'(1);
        if (cnt_q == IdxW'(NumWords - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_gnt_o = gnt;
  assign wr_en      = gnt & data_we_i & hit & ~slot_ro;
  assign rd_en      = gnt & ~data_we_i & hit & ~slot_ro;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  logic [Latency-1:0] vld_q;
  logic [Latency-1:0] err_q;
  logic [31:0]        rdat_q [Latency];
  logic [31:0]        rdat_in;

  assign rdat_in = rd_en ? mem_q[idx] : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        rdat_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= gnt;
      err_q[0]  <= gnt & ~hit;
      rdat_q[0] <= rdat_in;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        rdat_q[i] <= rdat_q[i-1];
      end
    end
  end

  assign data_rvalid_o = vld_q[Latency-1];
  assign data_err_o    = err_q[Latency-1];
  assign data_rdata_o  = rdat_q[Latency-1];

endmodule

// File: tb/tb_ibex_rf_store.sv
// Bench for ibex_rf_store: two instances (Latency 1 and 3) share stimulus; a per-instance
// scoreboard queue checks every response for cycle, data and error.
module tb_ibex_rf_store;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req, we, clear;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt1, rv1, er1, busy1;
  logic        gnt3, rv3, er3, busy3;
  logic [31:0] rd1, rd3;

  always #5 clk = ~clk;

  ibex_rf_store #(.BaseAddr(32'h0001_0000), .NumRegFiles(8), .Latency(1)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_ni), .data_req_i(req), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd1), .data_err_o(er1), .clear_i(clear), .busy_o(busy1)
  );

  ibex_rf_store #(.BaseAddr(32'h0001_0000), .NumRegFiles(8), .Latency(3)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_ni), .data_req_i(req), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd3), .data_err_o(er3), .clear_i(clear), .busy_o(busy3)
  );

`ifdef IBEX_RF_STORE_ZERO_X0_EN
  localparam bit ZeroX0 = 1'b1;
`else
  localparam bit ZeroX0 = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q [2][$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    if (q[k].size() > 0 && q[k][0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL rvalid_late dut%0d: got none expected at cycle %0d", k, q[k][0].due);
      void'(q[k].pop_front());
    end
    if (rv) begin
      if (q[k].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_unexpected dut%0d: got rvalid expected none (cycle %0d)", k, cyc);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("rvalid_cycle_dut%0d", k), 32'(cyc), 32'(e.due));
        chk($sformatf("rdata_dut%0d", k), rd, e.rdata);
        chk($sformatf("err_dut%0d", k), {31'b0, er}, {31'b0, e.err});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv1, er1, rd1);
    mon(1, rv3, er3, rd3);
  end

  task automatic push(input logic [31:0] rdata, input logic err);
    if (gnt1) q[0].push_back('{due: cyc + 1, err: err, rdata: rdata});
    if (gnt3) q[1].push_back('{due: cyc + 3, err: err, rdata: rdata});
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk);
    #1;
    req   = 1'b1;
    we    = w;
    be    = b;
    addr  = a;
    wdata = wd;
    @(negedge clk);
    chk("gnt_l1", {31'b0, gnt1}, 32'd1);
    chk("gnt_l3", {31'b0, gnt3}, 32'd1);
    push(exp_rd, exp_err);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  vec_t tbl [16];
  int   busy_cnt1, busy_cnt3, gnt_in_busy;
  bit   granted;

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 32'h0001_0084, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 32'h0001_0084, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0001_0088, 32'h1122_3344, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'h2, 32'h0001_0088, 32'h0000_AB00, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 32'h0001_0088, 32'h0, 32'h1122_AB44, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h0002_0000, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 32'h0002_0084, 32'h1234_5678, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 32'h0001_0084, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 32'h0001_0084, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 32'h0001_0084, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b1, 4'hF, 32'h0001_0080, 32'h0000_0005, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 32'h0001_0080, 32'h0, ZeroX0 ? 32'h0 : 32'h5, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 32'h0001_0087, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 32'h0000_FFFC, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 32'h0001_03FC, 32'hA5A5_A5A5, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 4'hF, 32'h0001_03FC, 32'h0, 32'hA5A5_A5A5, 1'b0};

    rst_ni = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    clear  = 1'b0;
    be     = 4'h0;
    addr   = 32'h0;
    wdata  = 32'h0;
    #7;
    chk("rst_gnt_l1", {31'b0, gnt1}, 32'd0);
    chk("rst_rvalid_l1", {31'b0, rv1}, 32'd0);
    chk("rst_rvalid_l3", {31'b0, rv3}, 32'd0);
    chk("rst_rdata_l3", rd3, 32'd0);
    chk("rst_err_l3", {31'b0, er3}, 32'd0);
    chk("rst_busy_l1", {31'b0, busy1}, 32'd0);
    chk("rst_busy_l3", {31'b0, busy3}, 32'd0);
    #10;
    rst_ni = 1'b1;

    // Table vectors issued back to back (read-after-write included).
    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err);
    end
    idle();

    // 32 spills then 32 fills of window 2.
    for (int i = 0; i < 32; i++) begin
      issue(1'b1, 4'hF, 32'h0001_0100 + 32'(i * 4), 32'hC0DE_0000 | 32'(i), 32'h0, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 4'hF, 32'h0001_0100 + 32'(i * 4), 32'h0,
            (ZeroX0 && i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i)), 1'b0);
    end

    // Clear with a request held; the last read drains during the clear.
    @(posedge clk);
    #1;
    clear = 1'b1;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h0001_0084;
    @(negedge clk);
    chk("gnt_clear_wins", {31'b0, gnt1}, 32'd0);
    @(posedge clk);
    #1;
    clear       = 1'b0;
    busy_cnt1   = 0;
    busy_cnt3   = 0;
    gnt_in_busy = 0;
    granted     = 1'b0;
    for (int c = 0; c < 300 && !granted; c++) begin
      @(negedge clk);
      if (busy3) busy_cnt3++;
      if (busy1) begin
        busy_cnt1++;
        if (gnt1 || gnt3) gnt_in_busy++;
      end else if (gnt1) begin
        granted = 1'b1;
        push(32'h0, 1'b0);
      end
      clear = (c == 10);  // ignored mid-clear
    end
    clear = 1'b0;
    chk("clear_busy_cycles_l1", 32'(busy_cnt1), 32'd256);
    chk("clear_busy_cycles_l3", 32'(busy_cnt3), 32'd256);
    chk("clear_gnt_while_busy", 32'(gnt_in_busy), 32'd0);
    chk("clear_req_granted_after", {31'b0, granted}, 32'd1);
    issue(1'b0, 4'hF, 32'h0001_03FC, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h0001_0114, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h0001_0088, 32'h0, 32'h0, 1'b0);

    // Reset mid-clear with two reads in flight on the Latency-3 instance.
    issue(1'b0, 4'hF, 32'h0001_0084, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h0001_0088, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    req   = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    #2;
    rst_ni = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    chk("abort_busy_l1", {31'b0, busy1}, 32'd0);
    chk("abort_busy_l3", {31'b0, busy3}, 32'd0);
    chk("abort_rvalid_l3", {31'b0, rv3}, 32'd0);
    #20;
    rst_ni = 1'b1;
    repeat (6) @(posedge clk);
    issue(1'b1, 4'hF, 32'h0001_01C8, 32'h600D_F00D, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h0001_01C8, 32'h0, 32'h600D_F00D, 1'b0);
    idle();

    for (int c = 0; c < 20 && (q[0].size() != 0 || q[1].size() != 0); c++) begin
      @(negedge clk);
    end
    chk("drain_l1", 32'(q[0].size()), 32'd0);
    chk("drain_l3", 32'(q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
